// File: rtl/jtag_pkg.sv
// jtag_pkg -- shared TAP definitions.
//   Default instruction length, standard opcodes, the mandatory
//   Capture-IR pattern and the one-hot data-register select type.
//   The DR mux and the TAP top use the select type as well.
package jtag_pkg;

   localparam int unsigned JTAG_IR_WIDTH = 4;

   localparam logic [3:0] JTAG_OP_EXTEST = 4'b0000;
   localparam logic [3:0] JTAG_OP_IDCODE = 4'b0001;
   localparam logic [3:0] JTAG_OP_SAMPLE = 4'b0010;
   localparam logic [3:0] JTAG_OP_BYPASS = 4'b1111;

   // Loaded into the two IR LSBs on Capture-IR; upper bits are zero.
   localparam logic [1:0] JTAG_IR_CAPTURE = 2'b01;

   // One-hot data-register select.
   typedef enum logic [3:0] {
      SEL_EXTEST = 4'b0001,
      SEL_SAMPLE = 4'b0010,
      SEL_IDCODE = 4'b0100,
      SEL_BYPASS = 4'b1000
   } jtag_sel_e;

endpackage

// File: rtl/jtag_ir_decode.sv
// jtag_ir_decode -- combinational opcode to one-hot DR select.
//   ir_i   : current instruction
//   sel_o  : one-hot select; any opcode not listed decodes to BYPASS
module jtag_ir_decode
   import jtag_pkg::*;
#(
   parameter int unsigned         IR_WIDTH  = JTAG_IR_WIDTH,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(JTAG_OP_EXTEST),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(JTAG_OP_IDCODE),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(JTAG_OP_SAMPLE)
) (
   input  logic [IR_WIDTH-1:0] ir_i,
   output jtag_sel_e           sel_o
);

   always_comb begin
      sel_o = SEL_BYPASS;
      // All-ones is BYPASS regardless of how the other opcodes are set,
      // so it is tested first.
      if (ir_i == '1)             sel_o = SEL_BYPASS;
      else if (ir_i == OP_EXTEST) sel_o = SEL_EXTEST;
      else if (ir_i == OP_IDCODE) sel_o = SEL_IDCODE;
      else if (ir_i == OP_SAMPLE) sel_o = SEL_SAMPLE;
   end

endmodule

// File: rtl/jtag_ir_ctrl.sv
// jtag_ir_ctrl -- TAP instruction-register path.
//   TRST       : async reset, active-high
//   ClockIR    : test clock
//   CaptureIR/ShiftIR/UpdateIR : TAP state enables, sampled on rising edge
//   TDI        : serial in
//   TDO/TDO_en : serial out and drive enable, retimed to falling edge
//   Instr      : updated instruction
//   Sel*       : one-hot DR select decoded from Instr
//   LenErr     : last update followed fewer than IR_WIDTH shifts
module jtag_ir_ctrl
   import jtag_pkg::*;
#(
   parameter int unsigned         IR_WIDTH  = JTAG_IR_WIDTH,
   parameter logic [IR_WIDTH-1:0] OP_EXTEST = IR_WIDTH'(JTAG_OP_EXTEST),
   parameter logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(JTAG_OP_IDCODE),
   parameter logic [IR_WIDTH-1:0] OP_SAMPLE = IR_WIDTH'(JTAG_OP_SAMPLE)
) (
   input  logic                TRST,
   input  logic                ClockIR,
   input  logic                CaptureIR,
   input  logic                ShiftIR,
   input  logic                UpdateIR,
   input  logic                TDI,
   output logic                TDO,
   output logic                TDO_en,
   output logic [IR_WIDTH-1:0] Instr,
   output logic                SelExtest,
   output logic                SelSample,
   output logic                SelIdcode,
   output logic                SelBypass,
   output logic                LenErr
);

   localparam int unsigned CW = $clog2(IR_WIDTH + 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(IR_WIDTH);

   logic [IR_WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [IR_WIDTH-1:0] ir_q;
   logic                len_err_q;
   logic                tdo_q, tdo_en_q;
   jtag_sel_e           sel;

   always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (CaptureIR) begin
         sr_d  = IR_WIDTH'(JTAG_IR_CAPTURE);
         cnt_d = '0;
      end else if (ShiftIR) begin
         sr_d = {TDI, sr_q[IR_WIDTH-1:1]};
         // Saturate so an over-long shift still reads as complete.
         if (cnt_q != CNT_FULL) cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge ClockIR or posedge TRST) begin
      if (TRST) begin
         sr_q      <= '0;
         cnt_q     <= '0;
         ir_q      <= OP_IDCODE;
         len_err_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         cnt_q <= cnt_d;
         // Update takes the pre-edge sr/cnt, so a concurrent shift does
         // not leak into the new instruction.
         if (UpdateIR) begin
            ir_q      <= sr_q;
            len_err_q <= (cnt_q < CNT_FULL);
         end
      end
   end

   // TDO changes on the falling edge, half a cycle after sr moves.
   always_ff @(negedge ClockIR or posedge TRST) begin
      if (TRST) begin
         tdo_q    <= 1'b0;
         tdo_en_q <= 1'b0;
      end else begin
         tdo_q    <= sr_q[0];
         tdo_en_q <= ShiftIR;
      end
   end

   jtag_ir_decode #(
      .IR_WIDTH  (IR_WIDTH),
      .OP_EXTEST (OP_EXTEST),
      .OP_IDCODE (OP_IDCODE),
      .OP_SAMPLE (OP_SAMPLE)
   ) u_decode (
      .ir_i  (ir_q),
      .sel_o (sel)
   );

   assign Instr     = ir_q;
   assign LenErr    = len_err_q;
   assign TDO       = tdo_q;
   assign TDO_en    = tdo_en_q;
   assign SelExtest = sel[0];
   assign SelSample = sel[1];
   assign SelIdcode = sel[2];
   assign SelBypass = sel[3];

endmodule

// File: tb/tb_jtag_ir_ctrl.sv
module tb_jtag_ir_ctrl;

   logic       TRST, ClockIR, CaptureIR, ShiftIR, UpdateIR, TDI;
   logic       TDO, TDO_en, LenErr;
   logic [3:0] Instr;
   logic       SelExtest, SelSample, SelIdcode, SelBypass;

   int errs = 0;
   int checks = 0;

   jtag_ir_ctrl dut (
      .TRST      (TRST),
      .ClockIR   (ClockIR),
      .CaptureIR (CaptureIR),
      .ShiftIR   (ShiftIR),
      .UpdateIR  (UpdateIR),
      .TDI       (TDI),
      .TDO       (TDO),
      .TDO_en    (TDO_en),
      .Instr     (Instr),
      .SelExtest (SelExtest),
      .SelSample (SelSample),
      .SelIdcode (SelIdcode),
      .SelBypass (SelBypass),
      .LenErr    (LenErr)
   );

   initial ClockIR = 1'b0;
   always #5 ClockIR = ~ClockIR;

   task automatic chk(input string tag, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // sel order: {Bypass, Idcode, Sample, Extest}
   task automatic chk_ir(input string tag, input logic [3:0] ins, input logic [3:0] sel,
                         input logic le);
      chk({tag, ".instr"}, {4'h0, Instr}, {4'h0, ins});
      chk({tag, ".sel"}, {4'h0, SelBypass, SelIdcode, SelSample, SelExtest}, {4'h0, sel});
      chk({tag, ".lenerr"}, {7'h0, LenErr}, {7'h0, le});
   endtask

   // Called just after a falling edge: drive enables, run one rising and
   // one falling edge, return sampled 1 time unit after the falling edge.
   task automatic cyc(input logic cap, input logic sh, input logic upd, input logic d);
      CaptureIR = cap; ShiftIR = sh; UpdateIR = upd; TDI = d;
      @(posedge ClockIR); #1;
      @(negedge ClockIR); #1;
      CaptureIR = 0; ShiftIR = 0; UpdateIR = 0; TDI = 0;
   endtask

   task automatic shift_chk(input string tag, input logic d, input logic exp_tdo);
      cyc(0, 1, 0, d);
      chk({tag, ".tdo"}, {7'h0, TDO}, {7'h0, exp_tdo});
      chk({tag, ".tdo_en"}, {7'h0, TDO_en}, 8'h01);
   endtask

   task automatic load(input logic [3:0] bits_lsb_first);
      cyc(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc(0, 1, 0, bits_lsb_first[i]);
      cyc(0, 0, 1, 0);
   endtask

   initial begin
      TRST = 1; CaptureIR = 0; ShiftIR = 0; UpdateIR = 0; TDI = 0;
      #12 TRST = 0;
      @(negedge ClockIR); #1;
      chk_ir("reset", 4'b0001, 4'b0100, 1'b0);
      chk("reset.tdo", {7'h0, TDO}, 8'h00);
      chk("reset.tdo_en", {7'h0, TDO_en}, 8'h00);

      // capture then shift 1,1,1,1: TDO 1 after capture, then 0,0,0,1
      cyc(1, 0, 0, 0);
      chk("cap.tdo", {7'h0, TDO}, 8'h01);
      chk("cap.tdo_en", {7'h0, TDO_en}, 8'h00);
      shift_chk("s1", 1, 0);
      shift_chk("s2", 1, 0);
      shift_chk("s3", 1, 0);
      shift_chk("s4", 1, 1);
      cyc(0, 0, 1, 0);
      chk_ir("bypass", 4'b1111, 4'b1000, 1'b0);

      load(4'b0010);
      chk_ir("sample", 4'b0010, 4'b0010, 1'b0);
      load(4'b0000);
      chk_ir("extest", 4'b0000, 4'b0001, 1'b0);

      // long shift 1,1,1,0,0,0: last four kept -> 0001
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 1); cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 0); cyc(0, 1, 0, 0);
      cyc(0, 0, 1, 0);
      chk_ir("long", 4'b0001, 4'b0100, 1'b0);

      // short shift 1,1 -> 1100, LenErr
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 1); cyc(0, 1, 0, 1);
      cyc(0, 0, 1, 0);
      chk_ir("short", 4'b1100, 4'b1000, 1'b1);
      load(4'b0010);
      chk_ir("full_after_short", 4'b0010, 4'b0010, 1'b0);

      // capture wins over shift
      cyc(1, 1, 0, 1);
      chk("capwin.tdo", {7'h0, TDO}, 8'h01);
      cyc(0, 0, 1, 0);
      chk_ir("capwin", 4'b0001, 4'b0100, 1'b1);

      // update with shift: ir gets pre-shift sr 0100, sr moves to 0010
      cyc(1, 0, 0, 0);
      cyc(0, 1, 0, 0); cyc(0, 1, 0, 1); cyc(0, 1, 0, 0);
      cyc(0, 1, 1, 0);
      chk_ir("upd_shift", 4'b0100, 4'b1000, 1'b1);
      cyc(0, 0, 1, 0);
      chk_ir("upd_after", 4'b0010, 4'b0010, 1'b0);

      // TRST mid-shift
      cyc(1, 0, 0, 0);
      CaptureIR = 0; ShiftIR = 1; TDI = 1;
      @(posedge ClockIR); #2;
      TRST = 1; #1;
      chk_ir("trst", 4'b0001, 4'b0100, 1'b0);
      chk("trst.tdo", {7'h0, TDO}, 8'h00);
      chk("trst.tdo_en", {7'h0, TDO_en}, 8'h00);
      ShiftIR = 0; TDI = 0;
      @(negedge ClockIR); #1;
      TRST = 0;
      // sr and cnt were cleared: update gives 0000 and a short-shift flag
      cyc(0, 0, 1, 0);
      chk_ir("post_trst", 4'b0000, 4'b0001, 1'b1);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/jtag_ir_ctrl.md
# jtag_ir_ctrl

Complete instruction-register path of the TAP: IR_WIDTH-bit capture/shift register, update (hold) register, opcode decoder and falling-edge TDO retiming. It sits directly downstream of the TAP controller, which supplies CaptureIR/ShiftIR/UpdateIR. It drives the data-register select lines (bypass, boundary-scan, IDCODE) and the IR contribution to the TDO mux.

## Interface
- IR_WIDTH, 4: instruction length, ≥2
- OP_EXTEST, 4'b0000: EXTEST opcode
- OP_IDCODE, 4'b0001: IDCODE opcode, also the reset instruction
- OP_SAMPLE, 4'b0010: SAMPLE/PRELOAD opcode
- OP_BYPASS: all ones; fixed by IEEE 1149.1, not overridable
- TRST  in  1  reset, asynchronous, active-high
- ClockIR  in  1  clock; free-running test clock for the IR path
- CaptureIR  in  1  capture enable (TAP Capture-IR)
- ShiftIR  in  1  shift enable (TAP Shift-IR)
- UpdateIR  in  1  update enable (TAP Update-IR)
- TDI  in  1  serial data in
- TDO  out  1  serial out, changes on falling ClockIR
- TDO_en  out  1  TDO valid/drive enable, falling-edge registered
- Instr  out  IR_WIDTH  current (updated) instruction
- SelExtest, SelSample, SelIdcode, SelBypass  out  1 each  one-hot decoded selects
- LenErr  out  1  last update followed a short shift

## Operation
- All enables are synchronous, sampled on rising ClockIR.
- Shift register sr[IR_WIDTH-1:0], reset 0:
  - CaptureIR: sr ← {0…0, 2'b01}; the 2'b01 pattern is mandatory.
  - else ShiftIR: sr ← {TDI, sr[IR_WIDTH-1:1]}; LSB goes out first.
  - else hold.
  - CaptureIR has priority over ShiftIR if both are high.
- Shift counter cnt, $clog2(IR_WIDTH+1) bits, reset 0:
  - cleared on CaptureIR.
  - incremented on each ShiftIR cycle; saturates at IR_WIDTH, no wrap.
- Update register ir, reset OP_IDCODE:
  - on UpdateIR: ir ← sr, using the pre-edge sr value even if ShiftIR is also high.
  - LenErr ← (cnt < IR_WIDTH), using the pre-edge cnt.
  - the update happens even when LenErr is set.
- Decode (combinational from ir, registered outputs not required):
  - exactly one Sel* is high at all times.
  - any unlisted opcode → SelBypass (standard rule).
- Instr = ir.
- TDO retiming, falling-edge flops:
  - TDO ← sr[0]
  - TDO_en ← ShiftIR
- Reset values: TDO=0, TDO_en=0, LenErr=0, Instr=OP_IDCODE, SelIdcode=1, other Sel*=0.
- TRST mid-shift aborts immediately. sr, cnt, ir and LenErr return to their reset values; no partial update occurs.

## Timing
- Capture to first TDO bit: sr[0]=1 after the CaptureIR rising edge; TDO shows it at the following falling edge.
- Each ShiftIR rising edge moves one bit. The new sr[0] reaches TDO half a cycle later.
- Update latency: Instr, Sel* and LenErr change at the UpdateIR rising edge, one edge, no extra pipeline.
- A shift longer than IR_WIDTH is legal. The last IR_WIDTH bits shifted in are kept, and LenErr=0.

## Structure
- Shared package jtag_pkg:
  - opcode localparams OP_EXTEST/IDCODE/SAMPLE/BYPASS
  - IR_WIDTH default
  - capture pattern constant
  - select one-hot enum/typedef, reused by the DR mux and the TAP top
- One sub-module, jtag_ir_decode: combinational opcode→one-hot decoder, reused by the boundary-scan control.
- Shift, counter, update and negedge flops stay in jtag_ir_ctrl.

## Test plan
- Reset → Instr=4'b0001, SelIdcode=1, TDO=0, TDO_en=0, LenErr=0. Pulse TRST mid-shift: same values are restored.
- CaptureIR, then 4 ShiftIR cycles with TDI=1,1,1,1 → TDO shows 1,0,0,0 on the falling edges. UpdateIR → Instr=4'b1111, SelBypass=1, LenErr=0.
- Shift in 0,1,0,0 (LSB first), then UpdateIR → Instr=4'b0010, SelSample=1. Repeat with 0,0,0,0 → SelExtest=1.
- Capture, then 2 shifts TDI=1,1, then UpdateIR → LenErr=1, Instr=4'b1100, SelBypass=1 (unlisted opcode). Next full 4-shift update → LenErr=0.
- Capture, then 6 shifts TDI=1,1,1,0,0,0, then UpdateIR → Instr=4'b0001 (last four bits kept), LenErr=0.
- CaptureIR and ShiftIR high together → sr=0001 (capture wins). UpdateIR together with ShiftIR → ir takes the pre-shift sr value.
